rans_axis_out: RTL and testbench

RANS_AXIS_OUT -- requirements
Module: rans_axis_out

---
 rtl/rans_pkg.sv | 25 ++
 rtl/rans_axis_out_if.sv | 22 ++
 rtl/rans_sync_fifo.sv | 77 +++++++
 rtl/rans_axis_out.sv | 167 ++++++++++++++++
 tb/tb_rans_axis_out.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rans_pkg.sv
// rtl/rans_pkg.sv - shared constants, frame FSM states and FIFO entry layout for rans_axis_out
package rans_pkg;

  localparam int DATA_W     = 64;
  localparam int WORD_BYTES = DATA_W / 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [WORD_BYTES-1:0] keep;
    logic                  last;
  } fifo_entry_t;

  // a legal last-word keep is non-zero and a single run of ones starting at byte 0
  function automatic logic keep_is_contiguous(input logic [WORD_BYTES-1:0] keep);
    logic [WORD_BYTES-1:0] plus_one;
    plus_one = keep + WORD_BYTES'(1);
    return (keep != '0) && ((keep & plus_one) == '0);
  endfunction

endpackage

// File: rtl/rans_axis_out_if.sv
// rtl/rans_axis_out_if.sv - AXI4-Stream bundle carried on the rans_axis_out output
interface rans_axis_out_if #(
  parameter int DATA_WIDTH = 64
);

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/rans_sync_fifo.sv
// rtl/rans_sync_fifo.sv - flop-based synchronous FIFO exposing the next head entry and next occupancy
module rans_sync_fifo
  import rans_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  fifo_entry_t push_entry_i,
  input  logic        pop_i,
  output logic        push_drop_o,
  output logic [AW:0] occupancy_next_o,
  output logic        head_valid_next_o,
  output fifo_entry_t head_next_o
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  fifo_entry_t   mem_q [DEPTH];
  fifo_entry_t   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // a pop frees the slot a same-cycle push needs, so a full FIFO still accepts push+pop
  always_comb begin
    full        = (count_q == FULL_CNT);
    do_pop      = pop_i && (count_q != '0);
    do_push     = push_i && (!full || do_pop);
    push_drop_o = push_i && !do_push;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry_i;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    occupancy_next_o  = count_d;
    head_valid_next_o = (count_d != '0);
    head_next_o       = mem_d[rd_ptr_d];
  end

  // pointers and occupancy; wrap is free because DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: entries are only observed while counted as occupied
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rans_axis_out.sv
// rtl/rans_axis_out.sv - rANS output stage to AXI4-Stream; define RANS_AXIS_OUT_STATS_EN for beat/frame counters
module rans_axis_out
  import rans_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    last_i,
  input  logic [DATA_WIDTH/8-1:0] last_keep_i,
  output logic                    ready_o,
  rans_axis_out_if.master         m_axis,
  output logic                    overflow_o,
  output logic                    keep_err_o,
  output logic                    frame_active_o,
  output logic [31:0]             word_count_o,
  output logic [31:0]             frame_count_o
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] READY_MAX = (AW+1)'(FIFO_DEPTH - 3);

  fifo_entry_t push_entry;
  fifo_entry_t head_next;
  logic        head_valid_next;
  logic [AW:0] occupancy_next;
  logic        keep_bad;
  logic        push_drop;
  logic        pop;

  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [DATA_WIDTH/8-1:0] tkeep_q, tkeep_d;
  logic                    ready_q, ready_d;
  logic                    overflow_q, overflow_d;
  logic                    keep_err_q, keep_err_d;

  frame_state_e state_q;
  logic         frame_active_q;

  // build the stored entry: non-last words are full, a bad last keep is forced to full
  always_comb begin
    keep_bad        = valid_i && last_i && !keep_is_contiguous(last_keep_i);
    push_entry.data = data_i;
    push_entry.keep = (last_i && !keep_bad) ? last_keep_i : '1;
    push_entry.last = last_i;
  end

  assign pop = tvalid_q && m_axis.tready;

  rans_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .push_i            (valid_i),
    .push_entry_i      (push_entry),
    .pop_i             (pop),
    .push_drop_o       (push_drop),
    .occupancy_next_o  (occupancy_next),
    .head_valid_next_o (head_valid_next),
    .head_next_o       (head_next)
  );

  // AXIS register tracks the next FIFO head; it only changes on a pop or on an empty-to-busy push
  always_comb begin
    tvalid_d   = head_valid_next;
    tdata_d    = head_valid_next ? head_next.data : '0;
    tkeep_d    = head_valid_next ? head_next.keep : '0;
    tlast_d    = head_valid_next && head_next.last;
    ready_d    = (occupancy_next <= READY_MAX);
    overflow_d = overflow_q | push_drop;
    keep_err_d = keep_err_q | keep_bad;
  end

  // output register, upstream ready and sticky error flags
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      keep_err_q <= 1'b0;
    end else begin
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
      keep_err_q <= keep_err_d;
    end
  end

  // input-side frame tracker: every push decides the state from last_i alone
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      frame_active_q <= 1'b0;
    end else if (valid_i) begin
      case (state_q)
        ST_IDLE: begin
          state_q        <= last_i ? ST_IDLE : ST_FRAME;
          frame_active_q <= !last_i;
        end
        ST_FRAME: begin
          state_q        <= last_i ? ST_IDLE : ST_FRAME;
          frame_active_q <= !last_i;
        end
        default: begin
          state_q        <= ST_IDLE;
          frame_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis.tvalid  = tvalid_q;
  assign m_axis.tlast   = tlast_q;
  assign m_axis.tdata   = tdata_q;
  assign m_axis.tkeep   = tkeep_q;
  assign ready_o        = ready_q;
  assign overflow_o     = overflow_q;
  assign keep_err_o     = keep_err_q;
  assign frame_active_o = frame_active_q;

`ifdef RANS_AXIS_OUT_STATS_EN
  logic [31:0] word_count_q, word_count_d;
  logic [31:0] frame_count_q, frame_count_d;

  // wrapping counts of accepted beats and of accepted frame ends
  always_comb begin
    word_count_d  = word_count_q;
    frame_count_d = frame_count_q;
    if (pop) begin
      word_count_d = word_count_q + 32'd1;
      if (tlast_q) begin
        frame_count_d = frame_count_q + 32'd1;
      end
    end
  end

  // statistics registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_count_q  <= '0;
      frame_count_q <= '0;
    end else begin
      word_count_q  <= word_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign word_count_o  = word_count_q;
  assign frame_count_o = frame_count_q;
`else
  assign word_count_o  = '0;
  assign frame_count_o = '0;
`endif

endmodule

// File: tb/tb_rans_axis_out.sv
// tb/tb_rans_axis_out.sv - self-checking bench for rans_axis_out with a queue-based reference model
module tb_rans_axis_out;

  localparam int DEPTH = 8;
`ifdef RANS_AXIS_OUT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [63:0] data_i;
  logic        last_i;
  logic [7:0]  last_keep_i;
  logic        ready_o;
  logic        overflow_o;
  logic        keep_err_o;
  logic        frame_active_o;
  logic [31:0] word_count_o;
  logic [31:0] frame_count_o;
  logic        s_tready;

  always #5 clk = ~clk;

  rans_axis_out_if #(.DATA_WIDTH(64)) axis ();
  assign axis.tready = s_tready;

  rans_axis_out #(
    .DATA_WIDTH (64),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .valid_i        (valid_i),
    .data_i         (data_i),
    .last_i         (last_i),
    .last_keep_i    (last_keep_i),
    .ready_o        (ready_o),
    .m_axis         (axis),
    .overflow_o     (overflow_o),
    .keep_err_o     (keep_err_o),
    .frame_active_o (frame_active_o),
    .word_count_o   (word_count_o),
    .frame_count_o  (frame_count_o)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } ent_t;

  ent_t        mq[$];
  bit          m_rst, m_ready, m_ovf, m_kerr, m_act, chk_en;
  int unsigned m_wc, m_fc;
  int          tests, fails;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit keep_ok(input logic [7:0] k);
    for (int n = 1; n <= 8; n++) begin
      if (k == 8'((1 << n) - 1)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // reference model: a plain queue of capacity DEPTH updated at every rising edge
  initial begin : model
    ent_t e;
    bit   pop;
    chk_en = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        m_rst = 1'b1; m_ready = 1'b0; m_ovf = 1'b0; m_kerr = 1'b0; m_act = 1'b0;
        m_wc = 0; m_fc = 0;
      end else begin
        m_rst = 1'b0;
        pop = (mq.size() != 0) && s_tready;
        if (pop) begin
          m_wc++;
          if (mq[0].l) m_fc++;
          void'(mq.pop_front());
        end
        if (valid_i) begin
          e.d = data_i;
          e.l = last_i;
          e.k = 8'hFF;
          if (last_i) begin
            if (keep_ok(last_keep_i)) e.k = last_keep_i;
            else m_kerr = 1'b1;
          end
          if (mq.size() >= DEPTH) m_ovf = 1'b1;
          else mq.push_back(e);
          m_act = !last_i;
        end
        m_ready = (mq.size() <= DEPTH - 3);
      end
      chk_en = 1'b1;
    end
  end

  // compare process: every falling edge, DUT outputs against the model
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("tvalid", 64'(axis.tvalid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
          chk("tdata", axis.tdata, mq[0].d);
          chk("tkeep", 64'(axis.tkeep), 64'(mq[0].k));
          chk("tlast", 64'(axis.tlast), 64'(mq[0].l));
        end
        if (m_rst) begin
          chk("rst_tdata", axis.tdata, 64'd0);
          chk("rst_tkeep", 64'(axis.tkeep), 64'd0);
          chk("rst_tlast", 64'(axis.tlast), 64'd0);
        end
        chk("ready_o", 64'(ready_o), 64'(m_ready));
        chk("overflow_o", 64'(overflow_o), 64'(m_ovf));
        chk("keep_err_o", 64'(keep_err_o), 64'(m_kerr));
        chk("frame_active_o", 64'(frame_active_o), 64'(m_act));
        chk("word_count_o", 64'(word_count_o), STATS ? 64'(m_wc) : 64'd0);
        chk("frame_count_o", 64'(frame_count_o), STATS ? 64'(m_fc) : 64'd0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input logic vv, input logic [63:0] dd, input logic ll,
                     input logic [7:0] kk, input logic tr);
    valid_i     = vv;
    data_i      = dd;
    last_i      = ll;
    last_keep_i = kk;
    s_tready    = tr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 64'd0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 64'd0, 1'b0, 8'h00, 1'b0);
  endtask

  logic [63:0] w [0:8];
  logic        lst;
  logic [7:0]  rk;
  int          idx, flen, n;

  initial begin : stim
    tests = 0;
    fails = 0;
    rst_n = 1'b0; valid_i = 1'b0; data_i = 64'd0; last_i = 1'b0;
    last_keep_i = 8'h00; s_tready = 1'b0;
    for (int i = 0; i < 9; i++) w[i] = {8{8'(8'hA0 + i)}};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", 64'(axis.tvalid), 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd0);
    rst_n = 1'b1;
    cyc(1'b0, 64'd0, 1'b0, 8'h00, 1'b1);
    chk("ready_first_edge", 64'(ready_o), 64'd1);

    // three-word frame, beats one cycle after each push
    cyc(1'b1, {8{8'h11}}, 1'b0, 8'h00, 1'b1);
    chk("f3_b1_data", axis.tdata, {8{8'h11}});
    chk("f3_b1_keep", 64'(axis.tkeep), 64'hFF);
    chk("f3_b1_last", 64'(axis.tlast), 64'd0);
    cyc(1'b1, {8{8'h22}}, 1'b0, 8'h00, 1'b1);
    chk("f3_b2_data", axis.tdata, {8{8'h22}});
    chk("f3_b2_last", 64'(axis.tlast), 64'd0);
    cyc(1'b1, {8{8'h33}}, 1'b1, 8'h0F, 1'b1);
    chk("f3_b3_data", axis.tdata, {8{8'h33}});
    chk("f3_b3_keep", 64'(axis.tkeep), 64'h0F);
    chk("f3_b3_last", 64'(axis.tlast), 64'd1);
    cyc(1'b0, 64'd0, 1'b0, 8'h00, 1'b1);
    chk("f3_idle", 64'(axis.tvalid), 64'd0);
    chk("f3_frames", 64'(frame_count_o), STATS ? 64'd1 : 64'd0);
    chk("f3_words", 64'(word_count_o), STATS ? 64'd3 : 64'd0);

    // fill with tready low, ninth push overflows, then drain
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, w[i], 1'b0, 8'h00, 1'b0);
      if (i == 4) chk("fill_ready_at5", 64'(ready_o), 64'd1);
      if (i == 5) chk("fill_ready_at6", 64'(ready_o), 64'd0);
      if (i == 7) chk("fill_no_ovf", 64'(overflow_o), 64'd0);
      if (i == 8) chk("fill_ovf", 64'(overflow_o), 64'd1);
    end
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_valid", 64'(axis.tvalid), 64'd1);
      chk("ovf_drain_data", axis.tdata, w[i]);
      cyc(1'b0, 64'd0, 1'b0, 8'h00, 1'b1);
    end
    chk("ovf_drain_end", 64'(axis.tvalid), 64'd0);

    // full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, w[i], 1'b0, 8'h00, 1'b0);
    cyc(1'b1, w[8], 1'b0, 8'h00, 1'b1);
    chk("full_pp_ovf", 64'(overflow_o), 64'd0);
    chk("full_pp_ready", 64'(ready_o), 64'd0);
    for (int i = 1; i < 9; i++) begin
      chk("full_pp_valid", 64'(axis.tvalid), 64'd1);
      chk("full_pp_data", axis.tdata, w[i]);
      cyc(1'b0, 64'd0, 1'b0, 8'h00, 1'b1);
    end
    chk("full_pp_end", 64'(axis.tvalid), 64'd0);

    // non-contiguous last keep is coerced
    do_reset();
    cyc(1'b1, {4{16'h5A5A}}, 1'b1, 8'h05, 1'b0);
    chk("badkeep_tkeep", 64'(axis.tkeep), 64'hFF);
    chk("badkeep_err", 64'(keep_err_o), 64'd1);
    chk("badkeep_last", 64'(axis.tlast), 64'd1);
    cyc(1'b0, 64'd0, 1'b0, 8'h00, 1'b1);

    // reset in the middle of an open frame
    do_reset();
    cyc(1'b1, w[0], 1'b0, 8'h00, 1'b0);
    cyc(1'b1, w[1], 1'b0, 8'h00, 1'b0);
    chk("mid_active", 64'(frame_active_o), 64'd1);
    rst_n = 1'b0;
    cyc(1'b0, 64'd0, 1'b0, 8'h00, 1'b0);
    chk("mid_rst_tvalid", 64'(axis.tvalid), 64'd0);
    chk("mid_rst_active", 64'(frame_active_o), 64'd0);
    rst_n = 1'b1;
    cyc(1'b0, 64'd0, 1'b0, 8'h00, 1'b1);
    chk("mid_after_tvalid", 64'(axis.tvalid), 64'd0);
    cyc(1'b1, {8{8'h77}}, 1'b1, 8'hFF, 1'b1);
    chk("mid_first_beat", axis.tdata, {8{8'h77}});
    cyc(1'b0, 64'd0, 1'b0, 8'h00, 1'b1);

    // random back-pressure, 1000 words in frames of 1..17
    do_reset();
    idx = 0;
    n = 0;
    flen = int'($urandom_range(1, 17));
    while (idx < 1000 && n < 20000) begin
      n++;
      if (m_ready) begin
        flen--;
        lst = (flen == 0) || (idx == 999);
        rk = 8'((1 << $urandom_range(1, 8)) - 1);
        cyc(1'b1, {$urandom, $urandom}, lst, rk, 1'($urandom_range(0, 1)));
        if (lst) flen = int'($urandom_range(1, 17));
        idx++;
      end else begin
        cyc(1'b0, 64'd0, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
      end
    end
    chk("rand_pushed", 64'(idx), 64'd1000);
    n = 0;
    while (mq.size() != 0 && n < 200) begin
      cyc(1'b0, 64'd0, 1'b0, 8'h00, 1'b1);
      n++;
    end
    chk("rand_drained", 64'(axis.tvalid), 64'd0);
    chk("rand_words", 64'(word_count_o), STATS ? 64'd1000 : 64'd0);
    chk("rand_no_ovf", 64'(overflow_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
